// File: rtl/pipe_pal_ingress.sv
// pipe_pal_ingress: elastic valid/ready input buffer feeding the pipe_pal stage.
// A DEPTH-entry circular buffer with wrap-bit pointers absorbs producer bursts
// and hides downstream stalls. Status outputs report occupancy.
// Optional build macro: PIPE_PAL_INGRESS_BYPASS_EN enables a fall-through path
// that presents s_data on m_data in the same cycle while the buffer is empty.
module pipe_pal_ingress #(
  parameter int W_DATA = 32,
  parameter int DEPTH  = 4,
  localparam int W_PTR = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W_DATA-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W_DATA-1:0] m_data,
  output logic [W_PTR:0]    o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_PTR:0]    wr_ptr;
  logic [W_PTR:0]    rd_ptr;
  logic              buf_empty;
  logic              buf_full;
  logic              push;
  logic              pop;
  logic              pass_through;

  // Status flags come purely from the pointer registers; the wrap bit tells
  // a full buffer apart from an empty one when the index bits match.
  always_comb begin
    buf_empty = (wr_ptr == rd_ptr);
    buf_full  = (wr_ptr[W_PTR-1:0] == rd_ptr[W_PTR-1:0]) &&
                (wr_ptr[W_PTR] != rd_ptr[W_PTR]);
    o_empty   = buf_empty;
    o_full    = buf_full;
    o_count   = wr_ptr - rd_ptr;
    s_ready   = !buf_full && !reset;
  end

`ifdef PIPE_PAL_INGRESS_BYPASS_EN
  // Consumer side with fall-through: an empty buffer forwards the producer
  // word directly, and a word taken that same cycle never touches storage.
  always_comb begin
    m_valid      = 1'b0;
    m_data       = '0;
    pass_through = 1'b0;
    if (!buf_empty) begin
      m_valid = 1'b1;
      m_data  = mem[rd_ptr[W_PTR-1:0]];
    end else if (s_valid && !reset) begin
      m_valid      = 1'b1;
      m_data       = s_data;
      pass_through = m_ready;
    end
    push = s_valid && s_ready && !pass_through;
    pop  = !buf_empty && m_ready;
  end
`else
  // Consumer side: the head word is shown only when stored, and the data bus
  // is held at zero while nothing is valid.
  always_comb begin
    m_valid      = !buf_empty;
    m_data       = '0;
    pass_through = 1'b0;
    if (!buf_empty) begin
      m_data = mem[rd_ptr[W_PTR-1:0]];
    end
    push = s_valid && s_ready;
    pop  = m_valid && m_ready;
  end
`endif

  // Pointer registers; reset discards any buffered words by re-aligning both.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage array is not reset; stale contents are never visible because
  // the read mux is gated by the empty flag.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[W_PTR-1:0]] <= s_data;
    end
  end

endmodule

// File: tb/tb_pipe_pal_ingress.sv
// tb_pipe_pal_ingress: directed self-checking bench for pipe_pal_ingress
// with DEPTH=4, W_DATA=32. Covers both the default and bypass builds.
module tb_pipe_pal_ingress;

  logic        i_clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [2:0]  o_count;
  logic        o_full;
  logic        o_empty;

  int testsRun;
  int testsFailed;

  pipe_pal_ingress #(
    .W_DATA(32),
    .DEPTH (4)
  ) dut (
    .i_clk  (i_clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .o_count(o_count),
    .o_full (o_full),
    .o_empty(o_empty)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Advance one rising edge and settle 1 unit past it before anything else.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence with hand-computed expectations.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    s_valid     = 1'b0;
    s_data      = 32'h0;
    m_ready     = 1'b0;

    applyStimulus();
    applyStimulus();
    checkOutput("reset_s_ready_low", 32'(s_ready), 32'd0);
    checkOutput("reset_empty", 32'(o_empty), 32'd1);

    // Reset release, idle.
    reset = 1'b0;
    #1;
    checkOutput("idle_s_ready", 32'(s_ready), 32'd1);
    checkOutput("idle_m_valid", 32'(m_valid), 32'd0);
    checkOutput("idle_m_data", m_data, 32'h0);
    checkOutput("idle_count", 32'(o_count), 32'd0);
    checkOutput("idle_empty", 32'(o_empty), 32'd1);
    checkOutput("idle_full", 32'(o_full), 32'd0);

    // Fill with consumer stalled.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 32'hA0 + 32'(i);
      applyStimulus();
      checkOutput($sformatf("fill_count_%0d", i), 32'(o_count), 32'(i + 1));
    end
    checkOutput("fill_full", 32'(o_full), 32'd1);
    checkOutput("fill_s_ready", 32'(s_ready), 32'd0);
    checkOutput("fill_empty", 32'(o_empty), 32'd0);

    // Fifth word offered while full is held off.
    s_data = 32'hA4;
    applyStimulus();
    applyStimulus();
    checkOutput("overflow_count", 32'(o_count), 32'd4);
    checkOutput("overflow_head", m_data, 32'hA0);
    checkOutput("overflow_m_valid", 32'(m_valid), 32'd1);

    // Drain from full.
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_data_%0d", i), m_data, 32'hA0 + 32'(i));
      checkOutput($sformatf("drain_valid_%0d", i), 32'(m_valid), 32'd1);
      applyStimulus();
    end
    checkOutput("drain_empty", 32'(o_empty), 32'd1);
    checkOutput("drain_m_valid", 32'(m_valid), 32'd0);
    checkOutput("drain_m_data", m_data, 32'h0);
    checkOutput("drain_count", 32'(o_count), 32'd0);

    // Streaming 10 words with both sides open; pointers wrap past index 3.
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data = 32'(k);
`ifdef PIPE_PAL_INGRESS_BYPASS_EN
      #1;
      checkOutput($sformatf("stream_bypass_data_%0d", k), m_data, 32'(k));
      applyStimulus();
      checkOutput($sformatf("stream_count_%0d", k), 32'(o_count), 32'd0);
`else
      applyStimulus();
      checkOutput($sformatf("stream_data_%0d", k), m_data, 32'(k));
      checkOutput($sformatf("stream_count_%0d", k), 32'(o_count), 32'd1);
`endif
    end
    s_valid = 1'b0;
    applyStimulus();
    checkOutput("stream_end_empty", 32'(o_empty), 32'd1);
    checkOutput("stream_end_m_valid", 32'(m_valid), 32'd0);

    // Reset mid-burst with three words buffered.
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'hB0 + 32'(i);
      applyStimulus();
    end
    checkOutput("burst_count", 32'(o_count), 32'd3);
    s_valid = 1'b0;
    reset   = 1'b1;
    #1;
    checkOutput("midreset_s_ready", 32'(s_ready), 32'd0);
    applyStimulus();
    checkOutput("midreset_count", 32'(o_count), 32'd0);
    checkOutput("midreset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("midreset_m_data", m_data, 32'h0);
    checkOutput("midreset_full", 32'(o_full), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("postreset_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 32'h55;
    applyStimulus();
    s_valid = 1'b0;
    #1;
    checkOutput("postreset_head", m_data, 32'h55);
    checkOutput("postreset_count", 32'(o_count), 32'd1);
    m_ready = 1'b1;
    applyStimulus();
    checkOutput("postreset_drained", 32'(o_empty), 32'd1);

    // Same-cycle behaviour when empty: bypass forwards, default build waits.
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_data  = 32'h77;
    #1;
`ifdef PIPE_PAL_INGRESS_BYPASS_EN
    checkOutput("bypass_m_valid", 32'(m_valid), 32'd1);
    checkOutput("bypass_m_data", m_data, 32'h77);
    applyStimulus();
    s_valid = 1'b0;
    #1;
    checkOutput("bypass_count", 32'(o_count), 32'd0);
    checkOutput("bypass_empty", 32'(o_empty), 32'd1);
`else
    checkOutput("latency_m_valid_same_cycle", 32'(m_valid), 32'd0);
    checkOutput("latency_m_data_same_cycle", m_data, 32'h0);
    applyStimulus();
    s_valid = 1'b0;
    #1;
    checkOutput("latency_m_valid_next", 32'(m_valid), 32'd1);
    checkOutput("latency_m_data_next", m_data, 32'h77);
    applyStimulus();
    checkOutput("latency_drained", 32'(o_empty), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pipe_pal_ingress.md
# pipe_pal_ingress

Elastic input buffer that sits directly upstream of the `pipe_pal` stage. It absorbs W_DATA-wide words from a producer over a valid/ready handshake and presents them in order to `pipe_pal`'s data input. A circular buffer of DEPTH entries decouples producer bursts from downstream stalls. Status outputs expose occupancy.

## Interface
Parameters:
- W_DATA, 32, data word width in bits.
- DEPTH, 4, number of buffer entries; must be a power of two and ≥ 2.
- W_PTR (localparam), $clog2(DEPTH), pointer index width.

Ports:
- i_clk, input, 1, sole clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- s_valid, input, 1, producer has a word on s_data.
- s_ready, output, 1, buffer can accept a word this cycle.
- s_data, input, W_DATA, producer word.
- m_valid, output, 1, word available on m_data.
- m_ready, input, 1, `pipe_pal` accepts the word this cycle.
- m_data, output, W_DATA, head-of-buffer word; forced to 0 whenever m_valid=0.
- o_count, output, W_PTR+1, current occupancy, 0..DEPTH.
- o_full, output, 1, o_count == DEPTH.
- o_empty, output, 1, o_count == 0.

## Operation
- Storage: DEPTH×W_DATA array, not reset. wr_ptr and rd_ptr are W_PTR+1 bits; the MSB is a wrap bit. Empty when the pointers are equal. Full when the index bits are equal and the wrap bits differ.
- Push = s_valid && s_ready. Writes mem[wr_ptr] and increments wr_ptr.
- Pop = m_valid && m_ready. Increments rd_ptr.
- s_ready = !o_full && !reset. There is no pass-through when full: a pop in a full cycle frees space only from the next cycle.
- m_valid = !o_empty. m_data = mem[rd_ptr].
- o_count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Pointer arithmetic wraps modulo 2·DEPTH. The index wraps from DEPTH−1 to 0.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Producer rule: s_data and s_valid must be held until accepted. The block does not check this.
- Consumer rule: once m_valid=1, m_valid stays 1 and m_data stays stable until a pop occurs.
- Reset (asserted in any cycle, including mid-burst):
  - Next edge: pointers = 0, o_count = 0, o_empty = 1, o_full = 0.
  - m_valid = 0, m_data = 0.
  - Buffered words are discarded.
  - s_ready = 0 while reset is high, and 1 in the first cycle after deassertion.

## Timing
- Without bypass: push-to-m_valid latency is 1 cycle. A word pushed at edge N is visible after edge N.
- Pop-to-next-word: the next word appears the cycle after the popping edge. Back-to-back pops sustain 1 word/cycle.
- Throughput is 1 word/cycle in each direction when neither side stalls.
- s_ready, m_valid, o_full, o_empty and o_count depend only on registered state (and reset). There is no combinational path from m_ready to s_ready.
- With the bypass enabled, s_data→m_data and s_valid→m_valid are combinational when the buffer is empty.

## Configuration
- PIPE_PAL_INGRESS_BYPASS_EN defined — fall-through bypass:
  - When empty and s_valid=1: m_valid=1 and m_data=s_data in the same cycle.
  - If m_ready=1 in that cycle, the word passes through without being written, and o_count stays 0.
  - If m_ready=0, the word is pushed normally.
  - Latency when empty becomes 0 cycles.
- Undefined (default): no bypass. Every word passes through storage with 1-cycle minimum latency, and all outputs are registered-state-driven.

## Test plan
- Reset then idle → s_ready=1, m_valid=0, m_data=0, o_count=0, o_empty=1 on the first cycle after reset drops.
- Fill (DEPTH=4, m_ready=0), push 0xA0..0xA3 → o_count steps 1,2,3,4; o_full=1; s_ready=0; a fifth word 0xA4 is held and not accepted.
- Drain from full with m_ready=1 → m_data reads 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles; then o_empty=1 and m_valid=0.
- Streaming with s_valid=m_ready=1 for 10 words 0x00..0x09 → output order matches input, o_count stays at 1 (0 with bypass), and pointers wrap past index 3 without corruption.
- Reset asserted with o_count=3 mid-burst → next cycle o_count=0 and m_valid=0; after release, a new word 0x55 emerges first.
- With PIPE_PAL_INGRESS_BYPASS_EN: when empty, s_valid=m_ready=1 with s_data=0x77 → m_valid=1 and m_data=0x77 in the same cycle, and o_count stays 0.
